// File: rtl/sram_nr1w_init.sv
// Multi-read, single-write register array with byte masking, optional registered reads
// and a hardware engine that fills every word with INIT_VALUE after reset or on request.
module sram_nr1w_init #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned READ_LATENCY = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           init_start,
    output logic                           ready,
    output logic                           init_busy,
    input  logic                           WE,
    input  logic [ADDR_WIDTH-1:0]          WriteAddress,
    input  logic [DATA_WIDTH-1:0]          WriteBus,
    input  logic [DATA_WIDTH/8-1:0]        WriteMask,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] ReadBus,
    output logic                           write_drop,
    output logic                           addr_error
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1 = ADDR_WIDTH + 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = AW1'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        StInit,
        StReady
    } state_e;

    state_e state_q, state_d;
    logic [IDX_W-1:0] init_count_q, init_count_d;
    logic write_drop_q, write_drop_d;
    logic addr_error_q, addr_error_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_in_range;
    logic                  user_wr;
    logic                  init_wr;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_word;

    logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ];
    logic [IDX_W-1:0]      rd_idx [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_word [NUM_READ];
    logic [NUM_READ-1:0]   rd_in_range;

    // Write decode and byte merge; wr_word doubles as the write-first forwarding value.
    always_comb begin
        wr_in_range = ({1'b0, WriteAddress} < DEPTH_LIM);
        wr_idx      = WriteAddress[IDX_W-1:0];
        init_wr     = (state_q == StInit);
        user_wr     = WE && (state_q == StReady) && wr_in_range;
        wr_old      = wr_in_range ? mem_q[wr_idx] : '0;
        wr_word     = wr_old;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (WriteMask[b]) begin
                wr_word[8*b +: 8] = WriteBus[8*b +: 8];
            end
        end
    end

    // Array lookups; out-of-range ports read as zero.
    always_comb begin
        for (int k = 0; k < NUM_READ; k++) begin
            rd_addr[k]     = ReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_idx[k]      = rd_addr[k][IDX_W-1:0];
            rd_in_range[k] = ({1'b0, rd_addr[k]} < DEPTH_LIM);
            rd_word[k]     = rd_in_range[k] ? mem_q[rd_idx[k]] : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_count_d = init_count_q;
        case (state_q)
            StInit: begin
                init_count_d = init_count_q + IDX_W'(1);
                if (init_count_q == LAST_IDX) begin
                    state_d      = StReady;
                    init_count_d = '0;
                end
            end
            StReady: begin
                if (init_start) begin
                    state_d      = StInit;
                    init_count_d = '0;
                end
            end
            default: begin
                state_d      = StInit;
                init_count_d = '0;
            end
        endcase
    end

    always_comb begin
        write_drop_d = WE && (!wr_in_range || (state_q != StReady));
        addr_error_d = (WE && !wr_in_range) || !(&rd_in_range);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StInit;
            init_count_q <= '0;
            write_drop_q <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_count_q <= init_count_d;
            write_drop_q <= write_drop_d;
            addr_error_q <= addr_error_d;
        end
    end

    // Contents survive reset; only the init engine clears them.
    always_ff @(posedge clock) begin
        if (init_wr) begin
            mem_q[init_count_q] <= INIT_VALUE;
        end else if (user_wr) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    assign ready      = (state_q == StReady);
    assign init_busy  = (state_q == StInit);
    assign write_drop = write_drop_q;
    assign addr_error = addr_error_q;

    if (READ_LATENCY == 0) begin : g_comb_read
        always_comb begin
            ReadBus = '0;
            for (int k = 0; k < NUM_READ; k++) begin
                ReadBus[k*DATA_WIDTH +: DATA_WIDTH] = rd_word[k];
            end
        end
    end else begin : g_reg_read
        logic [NUM_READ*DATA_WIDTH-1:0] rd_q, rd_d;

        // Write-first: a same-edge write to the read address is returned directly.
        always_comb begin
            rd_d = '0;
            for (int k = 0; k < NUM_READ; k++) begin
                rd_d[k*DATA_WIDTH +: DATA_WIDTH] = rd_word[k];
                if (rd_in_range[k]) begin
                    if (init_wr && (rd_idx[k] == init_count_q)) begin
                        rd_d[k*DATA_WIDTH +: DATA_WIDTH] = INIT_VALUE;
                    end else if (user_wr && (rd_idx[k] == wr_idx)) begin
                        rd_d[k*DATA_WIDTH +: DATA_WIDTH] = wr_word;
                    end
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign ReadBus = rd_q;
    end

endmodule

// File: tb/tb_sram_nr1w_init.sv
// Directed bench: a combinational 2-port instance and a registered 4-port instance
// driven by the same write/control stimulus.
module tb_sram_nr1w_init;

    localparam int DW = 128;
    localparam int AW = 16;
    localparam int DEP = 16;
    localparam logic [DW-1:0] IV = {16{8'hA5}};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic init_start = 1'b0;
    logic we = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    logic [DW/8-1:0] wm = '0;
    logic [2*AW-1:0] ra0 = '0;
    logic [4*AW-1:0] ra1 = '0;
    logic [2*DW-1:0] rb0;
    logic [4*DW-1:0] rb1;
    logic ready0, busy0, drop0, err0;
    logic ready1, busy1, drop1, err1;

    int n_total = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    sram_nr1w_init #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .NUM_READ(2),
        .READ_LATENCY(0), .INIT_VALUE(IV)
    ) u_dut0 (
        .clock(clock), .reset(reset), .init_start(init_start), .ready(ready0),
        .init_busy(busy0), .WE(we), .WriteAddress(wa), .WriteBus(wd), .WriteMask(wm),
        .ReadAddress(ra0), .ReadBus(rb0), .write_drop(drop0), .addr_error(err0)
    );

    sram_nr1w_init #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .NUM_READ(4),
        .READ_LATENCY(1), .INIT_VALUE(IV)
    ) u_dut1 (
        .clock(clock), .reset(reset), .init_start(init_start), .ready(ready1),
        .init_busy(busy1), .WE(we), .WriteAddress(wa), .WriteBus(wd), .WriteMask(wm),
        .ReadAddress(ra1), .ReadBus(rb1), .write_drop(drop1), .addr_error(err1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a);
        for (int k = 0; k < 2; k++) ra0[k*AW +: AW] = a;
        for (int k = 0; k < 4; k++) ra1[k*AW +: AW] = a;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_total++;
        if ({ready0, busy0, drop0, err0, ready1, busy1, drop1, err1} !== 8'b0100_0100) begin
            n_bad++;
            $display("FAIL reset_flags got=%b exp=01000100",
                     {ready0, busy0, drop0, err0, ready1, busy1, drop1, err1});
        end
        n_total++;
        if (rb1 !== '0) begin
            n_bad++;
            $display("FAIL reset_readbus got=%h exp=0", rb1);
        end
        reset = 1'b0;
    endtask

    task automatic test_power_up();
        for (int i = 1; i <= DEP; i++) begin
            tick();
            n_total++;
            if ({ready0, ready1, busy0, busy1} !== ((i == DEP) ? 4'b1100 : 4'b0011)) begin
                n_bad++;
                $display("FAIL powerup_ready edge=%0d got=%b", i, {ready0, ready1, busy0, busy1});
            end
        end
        for (int a = 0; a < DEP; a++) begin
            set_ra(AW'(a));
            #1;
            n_total++;
            if (rb0 !== {2{IV}}) begin
                n_bad++;
                $display("FAIL powerup_data0 addr=%0d got=%h exp=%h", a, rb0, {2{IV}});
            end
            tick();
            n_total++;
            if (rb1 !== {4{IV}}) begin
                n_bad++;
                $display("FAIL powerup_data1 addr=%0d got=%h exp=%h", a, rb1, {4{IV}});
            end
        end
    endtask

    task automatic test_mask_write();
        logic [DW-1:0] exp;
        exp = {64'hA5A5A5A5A5A5A5A5, 64'h8899AABBCCDDEEFF};
        we = 1'b1;
        wa = 16'd3;
        wd = 128'h00112233445566778899AABBCCDDEEFF;
        wm = 16'h00FF;
        tick();
        we = 1'b0;
        wm = '0;
        set_ra(16'd3);
        #1;
        n_total++;
        if (rb0 !== {2{exp}}) begin
            n_bad++;
            $display("FAIL mask_write0 got=%h exp=%h", rb0, {2{exp}});
        end
        n_total++;
        if ({drop0, err0, drop1, err1} !== 4'b0000) begin
            n_bad++;
            $display("FAIL mask_write_flags got=%b exp=0000", {drop0, err0, drop1, err1});
        end
        tick();
        n_total++;
        if (rb1 !== {4{exp}}) begin
            n_bad++;
            $display("FAIL mask_write1 got=%h exp=%h", rb1, {4{exp}});
        end
    endtask

    task automatic test_forward();
        logic [DW-1:0] exp;
        set_ra(16'd5);
        we = 1'b1;
        wa = 16'd5;
        wd = 128'h1234;
        wm = 16'hFFFF;
        #1;
        n_total++;
        if (rb0[0 +: DW] !== IV) begin
            n_bad++;
            $display("FAIL fwd_comb_old got=%h exp=%h", rb0[0 +: DW], IV);
        end
        tick();
        we = 1'b0;
        n_total++;
        if (rb1 !== {4{128'h1234}}) begin
            n_bad++;
            $display("FAIL fwd_reg_full got=%h exp=%h", rb1, {4{128'h1234}});
        end
        n_total++;
        if (rb0[0 +: DW] !== 128'h1234) begin
            n_bad++;
            $display("FAIL fwd_comb_after got=%h exp=1234", rb0[0 +: DW]);
        end
        // Partial mask: forwarded word must merge new low bytes with old high bytes.
        exp = {{12{8'hA5}}, {4{8'hFF}}};
        set_ra(16'd6);
        we = 1'b1;
        wa = 16'd6;
        wd = '1;
        wm = 16'h000F;
        tick();
        we = 1'b0;
        n_total++;
        if (rb1 !== {4{exp}}) begin
            n_bad++;
            $display("FAIL fwd_reg_partial got=%h exp=%h", rb1, {4{exp}});
        end
    endtask

    task automatic test_addr_errors();
        set_ra(16'd0);
        we = 1'b1;
        wa = 16'd16;
        wd = '1;
        wm = '1;
        tick();
        we = 1'b0;
        n_total++;
        if ({drop0, err0, drop1, err1} !== 4'b1111) begin
            n_bad++;
            $display("FAIL oor_write_pulse got=%b exp=1111", {drop0, err0, drop1, err1});
        end
        n_total++;
        if (rb0 !== {2{IV}}) begin
            n_bad++;
            $display("FAIL oor_write_alias got=%h exp=%h", rb0, {2{IV}});
        end
        tick();
        n_total++;
        if ({drop0, err0, drop1, err1} !== 4'b0000) begin
            n_bad++;
            $display("FAIL oor_write_clear got=%b exp=0000", {drop0, err0, drop1, err1});
        end
        ra0[AW +: AW] = 16'd20;
        ra1[AW +: AW] = 16'd20;
        #1;
        n_total++;
        if (rb0[DW +: DW] !== '0) begin
            n_bad++;
            $display("FAIL oor_read0 got=%h exp=0", rb0[DW +: DW]);
        end
        tick();
        n_total++;
        if (rb1[DW +: DW] !== '0) begin
            n_bad++;
            $display("FAIL oor_read1 got=%h exp=0", rb1[DW +: DW]);
        end
        n_total++;
        if ({err0, err1, drop0, drop1} !== 4'b1100) begin
            n_bad++;
            $display("FAIL oor_read_pulse got=%b exp=1100", {err0, err1, drop0, drop1});
        end
        set_ra(16'd0);
        tick();
        n_total++;
        if ({err0, err1} !== 2'b00) begin
            n_bad++;
            $display("FAIL oor_read_clear got=%b exp=00", {err0, err1});
        end
    endtask

    task automatic test_reinit();
        set_ra(16'd2);
        we = 1'b1;
        wa = 16'd2;
        wd = 128'hBEEF;
        wm = 16'hFFFF;
        init_start = 1'b1;
        tick();
        we = 1'b0;
        init_start = 1'b0;
        n_total++;
        if ({busy0, busy1, ready0, ready1} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reinit_enter got=%b exp=1100", {busy0, busy1, ready0, ready1});
        end
        n_total++;
        if (rb0[0 +: DW] !== 128'hBEEF || rb1[0 +: DW] !== 128'hBEEF) begin
            n_bad++;
            $display("FAIL reinit_same_cycle_write got=%h/%h exp=beef", rb0[0 +: DW], rb1[0 +: DW]);
        end
        for (int i = 1; i <= DEP; i++) begin
            if (i == 8) begin
                we = 1'b1;
                wa = 16'd4;
                wd = '0;
                wm = 16'hFFFF;
            end
            tick();
            we = 1'b0;
            n_total++;
            if ({busy0, busy1, ready0, ready1} !== ((i < DEP) ? 4'b1100 : 4'b0011)) begin
                n_bad++;
                $display("FAIL reinit_busy edge=%0d got=%b", i, {busy0, busy1, ready0, ready1});
            end
            if (i == 2) begin
                n_total++;
                if (rb1[0 +: DW] !== 128'hBEEF) begin
                    n_bad++;
                    $display("FAIL reinit_partial got=%h exp=beef", rb1[0 +: DW]);
                end
            end
            if (i == 3) begin
                n_total++;
                if (rb1[0 +: DW] !== IV) begin
                    n_bad++;
                    $display("FAIL reinit_init_fwd got=%h exp=%h", rb1[0 +: DW], IV);
                end
            end
            if (i == 8 || i == 9) begin
                n_total++;
                if ({drop0, drop1} !== ((i == 8) ? 2'b11 : 2'b00)) begin
                    n_bad++;
                    $display("FAIL init_drop edge=%0d got=%b", i, {drop0, drop1});
                end
            end
        end
        #1;
        n_total++;
        if (rb0 !== {2{IV}}) begin
            n_bad++;
            $display("FAIL reinit_addr2_comb got=%h exp=%h", rb0, {2{IV}});
        end
        tick();
        n_total++;
        if (rb1 !== {4{IV}}) begin
            n_bad++;
            $display("FAIL reinit_addr2_4port got=%h exp=%h", rb1, {4{IV}});
        end
        set_ra(16'd4);
        #1;
        n_total++;
        if (rb0 !== {2{IV}}) begin
            n_bad++;
            $display("FAIL init_drop_unchanged got=%h exp=%h", rb0, {2{IV}});
        end
        set_ra(16'd0);
    endtask

    task automatic test_reset_mid_init();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= DEP; i++) begin
            tick();
            n_total++;
            if ({ready0, ready1} !== ((i == DEP) ? 2'b11 : 2'b00)) begin
                n_bad++;
                $display("FAIL midinit_ready edge=%0d got=%b", i, {ready0, ready1});
            end
        end
    endtask

    task automatic test_init_start_held();
        init_start = 1'b1;
        tick();
        n_total++;
        if ({busy0, busy1} !== 2'b11) begin
            n_bad++;
            $display("FAIL held_enter got=%b exp=11", {busy0, busy1});
        end
        repeat (DEP) tick();
        n_total++;
        if ({ready0, ready1} !== 2'b11) begin
            n_bad++;
            $display("FAIL held_done got=%b exp=11", {ready0, ready1});
        end
        tick();
        n_total++;
        if ({busy0, busy1, ready0, ready1} !== 4'b1100) begin
            n_bad++;
            $display("FAIL held_rearm got=%b exp=1100", {busy0, busy1, ready0, ready1});
        end
        init_start = 1'b0;
        repeat (DEP) tick();
        n_total++;
        if ({ready0, ready1} !== 2'b11) begin
            n_bad++;
            $display("FAIL held_second_done got=%b exp=11", {ready0, ready1});
        end
    endtask

    task automatic test_async_reset();
        tick();
        reset = 1'b1;
        #1;
        n_total++;
        if ({ready0, busy0, ready1, busy1} !== 4'b0101) begin
            n_bad++;
            $display("FAIL async_reset got=%b exp=0101", {ready0, busy0, ready1, busy1});
        end
        n_total++;
        if (rb1 !== '0) begin
            n_bad++;
            $display("FAIL async_reset_readbus got=%h exp=0", rb1);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_mask_write();
        test_forward();
        test_addr_errors();
        test_reinit();
        test_reset_mid_init();
        test_init_start_held();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
